// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM row scheduler: command encodings,
// FSM state encoding and the default row-pointer width.
package sdram_sched_pkg;

   localparam int PTR_W_DEF = 15;

   typedef enum logic [1:0] {
      OP_WR  = 2'b00,
      OP_RD  = 2'b01,
      OP_REF = 2'b10
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

endpackage

// File: rtl/sdram_ring_ptr.sv
// Ring pointer with a wrap bit in the MSB; advances by one on incr and
// wraps modulo 2^W.
module sdram_ring_ptr #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         incr,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (incr) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/sdram_row_scheduler.sv
// Schedules whole-row writes, reads and refreshes onto an SDRAM command
// engine, tracking the stored rows as a ring of bank/row pointers.
module sdram_row_scheduler
   import sdram_sched_pkg::*;
#(
   parameter int PTR_W = PTR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_req,
   input  logic             rd_req,
   input  logic             ref_req,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [1:0]       cmd_op,
   output logic [1:0]       cmd_bank,
   output logic [PTR_W-3:0] cmd_row,
   input  logic             cmd_done,
   output logic             wr_ack,
   output logic             rd_ack,
   output logic             ref_ack,
   output logic             sdram_empty,
   output logic             sdram_full,
   output logic             busy
);

   // Handshake: a command transfers on the edge where cmd_valid && cmd_ready;
   // cmd_* hold steady from cmd_valid rising until that edge, and the engine
   // signals completion of the transferred command with a one-cycle cmd_done.

   state_t           state;
   op_t              op_q;
   logic             last_grant_rd;
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             wr_incr;
   logic             rd_incr;
   logic             wr_ok;
   logic             rd_ok;
   logic             contention;
   logic             grant_valid;
   op_t              grant_op;
   logic [PTR_W-1:0] grant_addr;

   sdram_ring_ptr #(.W(PTR_W + 1)) u_wr_ptr (
      .clk  (clk),
      .rst  (rst),
      .incr (wr_incr),
      .ptr  (wr_ptr)
   );

   sdram_ring_ptr #(.W(PTR_W + 1)) u_rd_ptr (
      .clk  (clk),
      .rst  (rst),
      .incr (rd_incr),
      .ptr  (rd_ptr)
   );

   assign wr_incr = (state == ST_WAIT) && cmd_done && (op_q == OP_WR);
   assign rd_incr = (state == ST_WAIT) && cmd_done && (op_q == OP_RD);

   assign sdram_empty = (wr_ptr == rd_ptr);
   assign sdram_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign wr_ok      = wr_req && !sdram_full;
   assign rd_ok      = rd_req && !sdram_empty;
   assign contention = !ref_req && wr_ok && rd_ok;

   assign cmd_op = op_q;
   assign busy   = (state != ST_IDLE);

   always_comb begin
      grant_valid = 1'b0;
      grant_op    = OP_WR;
      if (ref_req) begin
         grant_valid = 1'b1;
         grant_op    = OP_REF;
      end else if (contention) begin
         grant_valid = 1'b1;
         grant_op    = last_grant_rd ? OP_WR : OP_RD;
      end else if (wr_ok) begin
         grant_valid = 1'b1;
         grant_op    = OP_WR;
      end else if (rd_ok) begin
         grant_valid = 1'b1;
         grant_op    = OP_RD;
      end
   end

   always_comb begin
      grant_addr = '0;
      case (grant_op)
         OP_WR:   grant_addr = wr_ptr[PTR_W-1:0];
         OP_RD:   grant_addr = rd_ptr[PTR_W-1:0];
         default: grant_addr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         op_q          <= OP_WR;
         cmd_valid     <= 1'b0;
         cmd_bank      <= '0;
         cmd_row       <= '0;
         wr_ack        <= 1'b0;
         rd_ack        <= 1'b0;
         ref_ack       <= 1'b0;
         last_grant_rd <= 1'b1;
      end else begin
         wr_ack  <= 1'b0;
         rd_ack  <= 1'b0;
         ref_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  state     <= ST_ISSUE;
                  cmd_valid <= 1'b1;
                  op_q      <= grant_op;
                  cmd_bank  <= grant_addr[PTR_W-1 -: 2];
                  cmd_row   <= grant_addr[PTR_W-3:0];
                  // Only a genuine wr/rd contest moves the round-robin flag.
                  if (contention) begin
                     last_grant_rd <= (grant_op == OP_RD);
                  end
               end
            end
            ST_ISSUE: begin
               if (cmd_ready) begin
                  state     <= ST_WAIT;
                  cmd_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (cmd_done) begin
                  state   <= ST_IDLE;
                  wr_ack  <= (op_q == OP_WR);
                  rd_ack  <= (op_q == OP_RD);
                  ref_ack <= (op_q == OP_REF);
               end
            end
            default: begin
               state     <= ST_IDLE;
               cmd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_row_scheduler.sv
// Directed bench for sdram_row_scheduler; a reduced PTR_W keeps the
// fill-to-full sequence short while exercising the same wrap boundary.
module tb_sdram_row_scheduler;
   import sdram_sched_pkg::*;

   localparam int PTR_W = 10;
   localparam int DEPTH = 1 << PTR_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_req = 1'b0;
   logic             rd_req = 1'b0;
   logic             ref_req = 1'b0;
   logic             cmd_valid;
   logic             cmd_ready = 1'b0;
   logic [1:0]       cmd_op;
   logic [1:0]       cmd_bank;
   logic [PTR_W-3:0] cmd_row;
   logic             cmd_done = 1'b0;
   logic             wr_ack;
   logic             rd_ack;
   logic             ref_ack;
   logic             sdram_empty;
   logic             sdram_full;
   logic             busy;

   int n_asserts = 0;
   int n_fails   = 0;

   sdram_row_scheduler #(.PTR_W(PTR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wr_req),
      .rd_req      (rd_req),
      .ref_req     (ref_req),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_bank    (cmd_bank),
      .cmd_row     (cmd_row),
      .cmd_done    (cmd_done),
      .wr_ack      (wr_ack),
      .rd_ack      (rd_ack),
      .ref_ack     (ref_ack),
      .sdram_empty (sdram_empty),
      .sdram_full  (sdram_full),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ack_of(input logic [1:0] op);
      case (op)
         2'b00:   return 3'b100;
         2'b01:   return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   task automatic do_reset();
      wr_req = 1'b0; rd_req = 1'b0; ref_req = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for a command, checks its fields, optionally stalls cmd_ready, then accepts it.
   task automatic expect_issue(input logic [1:0] op, input logic [1:0] bank,
                               input logic [PTR_W-3:0] row, input int stall);
      int n;
      n = 0;
      cmd_ready = (stall == 0);
      @(negedge clk);
      while (!cmd_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_valid", cmd_valid, 1);
      chk("issue_op", cmd_op, op);
      chk("issue_bank", cmd_bank, bank);
      chk("issue_row", cmd_row, row);
      chk("issue_busy", busy, 1);
      for (int i = 0; i < stall; i++) begin
         cmd_done = (i == 1);
         @(negedge clk);
         chk("stall_valid", cmd_valid, 1);
         chk("stall_op", cmd_op, op);
         chk("stall_bank", cmd_bank, bank);
         chk("stall_row", cmd_row, row);
         chk("stall_no_ack", {wr_ack, rd_ack, ref_ack}, 0);
      end
      cmd_done  = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("accept_valid_low", cmd_valid, 0);
      chk("accept_busy", busy, 1);
   endtask

   // Pulses cmd_done 'delay' cycles after the accept edge and checks the completion.
   task automatic finish_cmd(input logic [1:0] op, input int delay,
                             input int exp_wr, input int exp_rd);
      for (int i = 1; i < delay; i++) begin
         @(negedge clk);
         chk("wait_no_ack", {wr_ack, rd_ack, ref_ack}, 0);
      end
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      chk("done_ack", {wr_ack, rd_ack, ref_ack}, ack_of(op));
      chk("done_wr_ptr", dut.wr_ptr, exp_wr);
      chk("done_rd_ptr", dut.rd_ptr, exp_rd);
      chk("done_busy", busy, 0);
   endtask

   initial begin
      // Reset then idle, including a read request against an empty ring.
      do_reset();
      @(negedge clk);
      chk("rst_empty", sdram_empty, 1);
      chk("rst_full", sdram_full, 0);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op", cmd_op, 0);
      chk("rst_bank", cmd_bank, 0);
      chk("rst_row", cmd_row, 0);
      chk("rst_acks", {wr_ack, rd_ack, ref_ack}, 0);
      rd_req = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("empty_rd_blocked", cmd_valid, 0);
      end
      rd_req = 1'b0;

      // Single write, done three cycles after accept.
      wr_req = 1'b1;
      expect_issue(2'b00, 2'd0, '0, 0);
      wr_req = 1'b0;
      finish_cmd(2'b00, 3, 1, 0);
      chk("one_wr_empty", sdram_empty, 0);
      @(negedge clk);
      chk("one_wr_ack_pulse", {wr_ack, rd_ack, ref_ack}, 0);

      // Round-robin with a refresh raised mid-WAIT.
      do_reset();
      wr_req = 1'b1;
      expect_issue(2'b00, 2'd0, 8'd0, 0);
      finish_cmd(2'b00, 1, 1, 0);
      expect_issue(2'b00, 2'd0, 8'd1, 0);
      finish_cmd(2'b00, 1, 2, 0);
      rd_req = 1'b1;
      expect_issue(2'b00, 2'd0, 8'd2, 0);
      finish_cmd(2'b00, 1, 3, 0);
      expect_issue(2'b01, 2'd0, 8'd0, 0);
      finish_cmd(2'b01, 1, 3, 1);
      expect_issue(2'b00, 2'd0, 8'd3, 0);
      ref_req = 1'b1;
      finish_cmd(2'b00, 2, 4, 1);
      expect_issue(2'b10, 2'd0, 8'd0, 0);
      ref_req = 1'b0;
      finish_cmd(2'b10, 1, 4, 1);
      expect_issue(2'b01, 2'd0, 8'd1, 0);
      wr_req = 1'b0;
      rd_req = 1'b0;
      finish_cmd(2'b01, 1, 4, 2);
      chk("rr_empty", sdram_empty, 0);

      // Fill to full, blocked write, one read, then write wraps to bank 0 row 0.
      do_reset();
      wr_req = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         expect_issue(2'b00, i[PTR_W-1 -: 2], i[PTR_W-3:0], 0);
         finish_cmd(2'b00, 1, i + 1, 0);
      end
      chk("fill_full", sdram_full, 1);
      chk("fill_empty", sdram_empty, 0);
      repeat (6) begin
         @(negedge clk);
         chk("full_wr_blocked", cmd_valid, 0);
         chk("full_idle", busy, 0);
      end
      wr_req = 1'b0;
      rd_req = 1'b1;
      expect_issue(2'b01, 2'd0, 8'd0, 0);
      rd_req = 1'b0;
      finish_cmd(2'b01, 1, DEPTH, 1);
      chk("rd_clears_full", sdram_full, 0);
      wr_req = 1'b1;
      expect_issue(2'b00, 2'd0, 8'd0, 0);
      wr_req = 1'b0;
      finish_cmd(2'b00, 1, DEPTH + 1, 1);
      chk("refull", sdram_full, 1);

      // Stalled cmd_ready with a cmd_done in ISSUE, then a stray cmd_done in IDLE.
      do_reset();
      wr_req = 1'b1;
      expect_issue(2'b00, 2'd0, 8'd0, 5);
      wr_req = 1'b0;
      finish_cmd(2'b00, 1, 1, 0);
      @(negedge clk);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      chk("stray_acks", {wr_ack, rd_ack, ref_ack}, 0);
      chk("stray_wr_ptr", dut.wr_ptr, 1);
      chk("stray_rd_ptr", dut.rd_ptr, 0);
      chk("stray_busy", busy, 0);

      // Reset in WAIT aborts the command; the late cmd_done is ignored.
      do_reset();
      wr_req = 1'b1;
      expect_issue(2'b00, 2'd0, 8'd0, 0);
      wr_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", cmd_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_state", dut.state, ST_IDLE);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      chk("abort_acks", {wr_ack, rd_ack, ref_ack}, 0);
      chk("abort_wr_ptr", dut.wr_ptr, 0);
      chk("abort_rd_ptr", dut.rd_ptr, 0);
      chk("abort_empty", sdram_empty, 1);
      chk("abort_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
